mode_sequencer: RTL

- Upstream controller for the stimulus block. It walks a range of MAIN_MODE values at a fixed SUB_MODE.
- For each mode it pulses CLR, waits a settle time, then dwells for a programmed number of cycles.
- At dwell end it snapshots the receive and error counters returned from the stimulus path. It presents one result record per mode on a valid/ready port to the host/readout logic.

---
 rtl/mode_sequencer_pkg.sv | 27 ++
 rtl/mode_sequencer_timer.sv | 43 ++++
 rtl/mode_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mode_sequencer_pkg.sv
// ============================================================================
// mode_sequencer_pkg : shared widths, defaults and state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mode_sequencer_pkg;

  localparam int MODE_W = 8;
  localparam int RECV_W = 58;
  localparam int ERR_W  = 64;
  localparam int TMR_W  = 32;

  localparam logic [MODE_W-1:0] IDLE_MODE_DEF = 8'd31;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_DWELL   = 3'd3,
    S_CAPTURE = 3'd4,
    S_REPORT  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mode_sequencer_timer.sv
// ============================================================================
// seq_timer : loadable down-counter with zero flag, parks at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_timer
  import mode_sequencer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mode_sequencer.sv
// ============================================================================
// mode_sequencer : sweeps MAIN_MODE over a range, clearing, settling and
//                  dwelling per mode, then reports counter snapshots
// Rev 1.0
// ============================================================================
`default_nettype none

module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int                SETTLE_CYC = 1024,
  parameter int                CLR_CYC    = 4,
  parameter logic [MODE_W-1:0] IDLE_MODE  = IDLE_MODE_DEF
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              START,
  input  logic              ABORT,
  input  logic [MODE_W-1:0] FIRST_MODE,
  input  logic [MODE_W-1:0] LAST_MODE,
  input  logic [MODE_W-1:0] SUB_MODE_IN,
  input  logic [TMR_W-1:0]  DWELL,
  output logic [MODE_W-1:0] MAIN_MODE,
  output logic [MODE_W-1:0] SUB_MODE,
  output logic              CLR,
  input  logic [RECV_W-1:0] RECV_CNT,
  input  logic [ERR_W-1:0]  ERR_CNT,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [MODE_W-1:0] RES_MODE,
  output logic [RECV_W-1:0] RES_RECV,
  output logic [ERR_W-1:0]  RES_ERR,
  output logic              RES_FAIL,
  output logic              BUSY,
  output logic              DONE
);

  // Timer holds N-1 on phase entry so each phase lasts exactly N cycles.
  localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   cur_q, cur_d;
  logic [MODE_W-1:0]   last_q, last_d;
  logic [MODE_W-1:0]   sub_q, sub_d;
  logic [TMR_W-1:0]    dwell_q, dwell_d;
  logic [MODE_W-1:0]   main_q, main_d;
  logic                clr_q, clr_d;
  logic                res_valid_q, res_valid_d;
  logic [MODE_W-1:0]   res_mode_q, res_mode_d;
  logic [RECV_W-1:0]   res_recv_q, res_recv_d;
  logic [ERR_W-1:0]    res_err_q, res_err_d;
  logic                res_fail_q, res_fail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_zero;

  seq_timer #(.W(TMR_W)) u_timer (
    .clk        (CLK),
    .rst_n      (RSTX),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    sub_d       = sub_q;
    dwell_d     = dwell_q;
    res_valid_d = res_valid_q;
    res_mode_d  = res_mode_q;
    res_recv_d  = res_recv_q;
    res_err_d   = res_err_q;
    res_fail_d  = res_fail_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    if (ABORT) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            cur_d    = FIRST_MODE;
            last_d   = (FIRST_MODE > LAST_MODE) ? FIRST_MODE : LAST_MODE;
            sub_d    = SUB_MODE_IN;
            dwell_d  = (DWELL == '0) ? TMR_W'(1) : DWELL;
            state_d  = S_APPLY;
            tmr_load = 1'b1;
            tmr_val  = CLR_LOAD;
          end
        end
        S_APPLY: begin
          if (tmr_zero) begin
            state_d  = S_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (tmr_zero) begin
            state_d  = S_DWELL;
            tmr_load = 1'b1;
            tmr_val  = dwell_q - 1'b1;
          end
        end
        S_DWELL: begin
          if (tmr_zero) begin
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          res_recv_d  = RECV_CNT;
          res_err_d   = ERR_CNT;
          res_mode_d  = cur_q;
          res_fail_d  = (ERR_CNT != '0) || (RECV_CNT == '0);
          res_valid_d = 1'b1;
          state_d     = S_REPORT;
        end
        S_REPORT: begin
          if (res_valid_q && RES_READY) begin
            res_valid_d = 1'b0;
            if (cur_q == last_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              cur_d    = cur_q + 1'b1;
              state_d  = S_APPLY;
              tmr_load = 1'b1;
              tmr_val  = CLR_LOAD;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Drive outputs from the next state so they are registered yet aligned.
    clr_d  = (state_d == S_APPLY);
    busy_d = (state_d != S_IDLE);
    main_d = busy_d ? cur_d : IDLE_MODE;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      sub_q       <= '0;
      dwell_q     <= '0;
      main_q      <= IDLE_MODE;
      clr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_mode_q  <= '0;
      res_recv_q  <= '0;
      res_err_q   <= '0;
      res_fail_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      sub_q       <= sub_d;
      dwell_q     <= dwell_d;
      main_q      <= main_d;
      clr_q       <= clr_d;
      res_valid_q <= res_valid_d;
      res_mode_q  <= res_mode_d;
      res_recv_q  <= res_recv_d;
      res_err_q   <= res_err_d;
      res_fail_q  <= res_fail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign MAIN_MODE = main_q;
  assign SUB_MODE  = sub_q;
  assign CLR       = clr_q;
  assign RES_VALID = res_valid_q;
  assign RES_MODE  = res_mode_q;
  assign RES_RECV  = res_recv_q;
  assign RES_ERR   = res_err_q;
  assign RES_FAIL  = res_fail_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

`default_nettype wire
